// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code enumeration and default datapath width.
// Imported by the ALU and by every pipeline stage that carries an op-code.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU, zero latency, no flow control.
// carry = unsigned carry-out for ADD, borrow (a < b unsigned) for SUB; 0 otherwise.
module alu
  import alu_pkg::*;
#(
  parameter int W = ALU_DATA_WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [W-1:0] result_o,
  output logic         zero_o,
  output logic         carry_o,
  output logic         overflow_o
);

  localparam int SW = $clog2(W);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        result_o   = sum[W-1:0];
        carry_o    = sum[W];
        overflow_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      ALU_SUB: begin
        result_o   = diff[W-1:0];
        carry_o    = diff[W];
        overflow_o = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLT: result_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLL: result_o = a_i << b_i[SW-1:0];
      ALU_SRL: result_o = a_i >> b_i[SW-1:0];
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/ex_stage.sv
// Two-slot execute stage (S1 operands -> ALU -> S2 result), 2-edge latency, 1 bundle/cycle.
// Valid/ready both sides; S2 holds under out_ready low, in_ready drops once both slots are full.
module ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  alu_op_e               in_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_overflow,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [31:0]           retired
);

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  alu_op_e               s1_op_q, s1_op_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_result_q, s2_result_d;
  logic                  s2_zero_q, s2_zero_d;
  logic                  s2_carry_q, s2_carry_d;
  logic                  s2_ovf_q, s2_ovf_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;
  logic [31:0]           retired_q, retired_d;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero, alu_carry, alu_ovf;
  logic                  accept, advance, out_hs;

  alu #(.W(DATA_WIDTH)) u_alu (
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .op_i       (s1_op_q),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .carry_o    (alu_carry),
    .overflow_o (alu_ovf)
  );

  assign advance  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !flush && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_carry_d  = s2_carry_q;
    s2_ovf_d    = s2_ovf_q;
    s2_tag_d    = s2_tag_q;
    retired_d   = retired_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
      s1_tag_d   = in_tag;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      s2_valid_d  = 1'b1;
      s2_result_d = alu_result;
      s2_zero_d   = alu_zero;
      s2_carry_d  = alu_carry;
      s2_ovf_d    = alu_ovf;
      s2_tag_d    = s1_tag_q;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end

    // A flush kills the S2 bundle too, so it is not counted as retired.
    if (out_hs && !flush) retired_d = retired_q + 32'd1;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= ALU_ADD;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_carry_q  <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_tag_q    <= '0;
      retired_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_carry_q  <= s2_carry_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_tag_q    <= s2_tag_d;
      retired_q   <= retired_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_zero     = s2_zero_q;
  assign out_carry    = s2_carry_q;
  assign out_overflow = s2_ovf_q;
  assign out_tag      = s2_tag_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed bundles push expected results,
// a negedge monitor pops on each output handshake and checks hold-while-stalled.
module tb_ex_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  alu_op_e     in_op;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_carry, out_overflow;
  logic [4:0]  out_tag;
  logic [31:0] retired;

  ex_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .in_tag       (in_tag),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_tag      (out_tag),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        z, c, v;
    logic [4:0]  tag;
    bit          lat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   acc;

  bit          hold_prev = 1'b0;
  logic [31:0] hold_r;
  logic [7:0]  hold_misc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a bundle and wait (bounded) for in_ready; on acceptance the expected
  // response goes into the scoreboard. Returns at the negedge before the accept edge.
  task automatic offer(input logic [31:0] a, input logic [31:0] b, input alu_op_e op,
                       input logic [4:0] tag, input logic [31:0] er, input logic ez,
                       input logic ec, input logic ev, input bit lat, input int budget,
                       output bit ok);
    exp_t e;
    @(posedge clk); #2;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = '{r: er, z: ez, c: ec, v: ev, tag: tag, lat: lat, cyc: cyc};
        sb.push_back(e);
        ok = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'hBAAD_F00D; in_op = ALU_XOR; in_tag = 5'd31;
  endtask

  task automatic drain(input logic [31:0] exp_retired, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    chk({name, "_drained"}, {31'b0, done}, 32'd1);
    chk({name, "_retired"}, retired, exp_retired);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && hold_prev) begin
      chk("hold_result", out_result, hold_r);
      chk("hold_flags_tag", {24'b0, out_zero, out_carry, out_overflow, out_tag}, {24'b0, hold_misc});
    end
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0d result 0x%08h, expected no output", out_tag, out_result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", out_result, mon_e.r);
        chk("flags_zcv", {29'b0, out_zero, out_carry, out_overflow}, {29'b0, mon_e.z, mon_e.c, mon_e.v});
        chk("tag", {27'b0, out_tag}, {27'b0, mon_e.tag});
        if (mon_e.lat) chk("latency", 32'(cyc - mon_e.cyc), 32'd2);
      end
    end
    hold_prev = rst_n && out_valid && !out_ready;
    hold_r    = out_result;
    hold_misc = {out_zero, out_carry, out_overflow, out_tag};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = ALU_ADD; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags_tag", {24'b0, out_zero, out_carry, out_overflow, out_tag}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Carry-out wrap to zero, then signed overflow
    out_ready = 1'b1;
    offer(32'hFFFF_FFFF, 32'h1, ALU_ADD, 5'd3, 32'h0, 1, 1, 0, 1, 4, acc);
    chk("acc_add_carry", {31'b0, acc}, 32'd1);
    idle();
    drain(32'd1, "add_carry");
    offer(32'h7FFF_FFFF, 32'h1, ALU_ADD, 5'd7, 32'h8000_0000, 0, 0, 1, 1, 4, acc);
    chk("acc_add_ovf", {31'b0, acc}, 32'd1);
    idle();
    drain(32'd2, "add_ovf");

    // Four back-to-back bundles, one per cycle
    offer(32'd5, 32'd3, ALU_SUB, 5'd10, 32'd2, 0, 0, 0, 1, 4, acc);
    offer(32'h0000_F0F0, 32'h0000_0FF0, ALU_AND, 5'd11, 32'h0000_00F0, 0, 0, 0, 1, 1, acc);
    offer(32'h0000_AAAA, 32'h0000_AAAA, ALU_XOR, 5'd12, 32'h0, 1, 0, 0, 1, 1, acc);
    offer(32'hFFFF_FFFF, 32'h1, ALU_SLT, 5'd13, 32'h1, 0, 0, 0, 1, 1, acc);
    chk("acc_b2b_last", {31'b0, acc}, 32'd1);
    idle();
    drain(32'd6, "b2b");

    // Backpressure: two accepted, third refused, outputs held
    out_ready = 1'b0;
    offer(32'd1, 32'd1, ALU_ADD, 5'd1, 32'd2, 0, 0, 0, 0, 4, acc);
    offer(32'd0, 32'd1, ALU_SUB, 5'd2, 32'hFFFF_FFFF, 0, 1, 0, 0, 4, acc);
    chk("acc_stall_second", {31'b0, acc}, 32'd1);
    offer(32'h1234_5678, 32'h1, ALU_OR, 5'd9, 32'h0, 0, 0, 0, 0, 4, acc);
    chk("stall_third_refused", {31'b0, acc}, 32'd0);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    idle();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 out_ready = 1'b1;
    drain(32'd8, "stall");

    // Flush with both slots full
    out_ready = 1'b0;
    offer(32'd10, 32'd20, ALU_ADD, 5'd20, 32'd30, 0, 0, 0, 0, 4, acc);
    offer(32'd3, 32'd4, ALU_ADD, 5'd21, 32'd7, 0, 0, 0, 0, 4, acc);
    idle();
    #0 flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_retired", retired, 32'd8);
    out_ready = 1'b1;
    offer(32'd100, 32'd200, ALU_ADD, 5'd5, 32'd300, 0, 0, 0, 1, 4, acc);
    chk("acc_after_flush", {31'b0, acc}, 32'd1);
    idle();
    drain(32'd9, "after_flush");

    // Asynchronous reset mid-stream
    offer(32'd1, 32'd2, ALU_ADD, 5'd3, 32'd3, 0, 0, 0, 0, 4, acc);
    offer(32'd4, 32'd5, ALU_ADD, 5'd4, 32'd9, 0, 0, 0, 0, 4, acc);
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_retired", retired, 32'd0);
    sb.delete();
    #10 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_midrst_out_valid", {31'b0, out_valid}, 32'd0);
    end
    chk("post_midrst_in_ready", {31'b0, in_ready}, 32'd1);
    offer(32'd2, 32'd2, ALU_ADD, 5'd6, 32'd4, 0, 0, 0, 1, 4, acc);
    chk("acc_after_rst", {31'b0, acc}, 32'd1);
    idle();
    drain(32'd1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
